// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// FSM state encoding used by serial_subtractor.
package serial_subtractor_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Index of the last processed bit for a given width.
  function automatic int last_bit(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Full subtractor from two half subtractors and an OR.
// Ports: a, b, borrow_in in; diff, borrow_out out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .a      (a),
    .b      (b),
    .diff   (d1),
    .borrow (b1)
  );

  // Second stage subtracts the incoming borrow.
  half_subtractor u_hs1 (
    .a      (d1),
    .b      (borrow_in),
    .diff   (diff),
    .borrow (b2)
  );

  assign borrow_out = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// Half subtractor cell: a - b.
// Ports: a, b in; diff = a^b, borrow = ~a&b out.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Ports: clk, rst, start, minuend, subtrahend in;
// busy, done, difference, borrow_out out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out
);

  import serial_subtractor_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(last_bit(WIDTH));

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             bo;
  logic [WIDTH-1:0] d_next;

  full_subtractor u_fs (
    .a          (a_sr[0]),
    .b          (b_sr[0]),
    .borrow_in  (brw),
    .diff       (d),
    .borrow_out (bo)
  );

  // New bit enters at the MSB; shift form also holds for WIDTH=1.
  always_comb begin
    d_next = (d_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));
  end

  assign busy = (state == ST_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      done       <= 1'b0;
      difference <= '0;
      borrow_out <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= minuend;
            b_sr  <= subtrahend;
            d_sr  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_next;
          brw  <= bo;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            difference <= d_next;
            borrow_out <= bo;
            done       <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Scoreboard queue of expected results, checked per scenario task.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] minuend = '0;
  logic [7:0] subtrahend = '0;
  logic       busy;
  logic       done;
  logic [7:0] difference;
  logic       borrow_out;

  typedef struct {
    logic [7:0] d;
    logic       b;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [8:0] full;
    full = {1'b0, a} - {1'b0, b};
    e.d = full[7:0];
    e.b = (a < b);
    return e;
  endfunction

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    minuend = a;
    subtrahend = b;
    start = 1'b1;
    q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    e = q.pop_front();
    total++;
    if (difference !== e.d || borrow_out !== e.b) begin
      bad++;
      $display("FAIL %s: got diff=%h brw=%b, want diff=%h brw=%b",
               name, difference, borrow_out, e.d, e.b);
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        difference !== 8'h00 || borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b diff=%h brw=%b, want 0 0 00 0",
               busy, done, difference, borrow_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit got;
    launch(8'h5A, 8'h23);
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || difference !== 8'h00) begin
        bad++;
        $display("FAIL busy_window k=%0d: busy=%b done=%b diff=%h, want 1 0 00",
                 k, busy, done, difference);
      end
      @(posedge clk);
      #1;
    end
    got = (done === 1'b1);
    total++;
    if (!got || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_latency: done=%b busy=%b, want 1 0", done, busy);
    end
    check_pop("5A-23");
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || difference !== 8'h37) begin
      bad++;
      $display("FAIL done_pulse: done=%b diff=%h, want 0 37", done, difference);
    end
  endtask

  task automatic test_wrap;
    bit got;
    logic [7:0] av [3] = '{8'h10, 8'h00, 8'hFF};
    logic [7:0] bv [3] = '{8'h20, 8'h01, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      launch(av[i], bv[i]);
      wait_done(got);
      total++;
      if (!got) begin
        bad++;
        $display("FAIL wrap_timeout i=%0d: got no done, want done", i);
        void'(q.pop_front());
      end else begin
        check_pop($sformatf("wrap%0d", i));
      end
    end
  endtask

  task automatic test_ignore_start;
    bit got;
    launch(8'h80, 8'h01);
    @(posedge clk);
    @(posedge clk);
    #1;
    minuend = 8'h00;
    subtrahend = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(got);
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ignore_timeout: got no done, want done");
      void'(q.pop_front());
    end else begin
      check_pop("80-01");
    end
    wait_done(got);
    total++;
    if (got || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_extra: done=%b busy=%b, want 0 0", got, busy);
    end
  endtask

  task automatic test_abort;
    bit got;
    launch(8'h05, 8'h07);
    void'(q.pop_front());
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        difference !== 8'h00 || borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL abort: busy=%b done=%b diff=%h brw=%b, want 0 0 00 0",
               busy, done, difference, borrow_out);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_done(got);
    total++;
    if (got) begin
      bad++;
      $display("FAIL abort_done: done=1, want 0");
    end
    launch(8'h01, 8'h00);
    wait_done(got);
    total++;
    if (!got) begin
      bad++;
      $display("FAIL after_abort_timeout: got no done, want done");
      void'(q.pop_front());
    end else begin
      check_pop("01-00");
    end
  endtask

  task automatic test_back_to_back;
    bit got;
    int last;
    @(negedge clk);
    minuend = 8'h09;
    subtrahend = 8'h04;
    start = 1'b1;
    last = -1;
    for (int n = 0; n < 3; n++) begin
      q.push_back(model(8'h09, 8'h04));
      wait_done(got);
      total++;
      if (!got) begin
        bad++;
        $display("FAIL b2b_timeout n=%0d: got no done, want done", n);
        void'(q.pop_front());
      end else begin
        check_pop($sformatf("b2b%0d", n));
        if (last >= 0) begin
          total++;
          if (cyc - last != 9) begin
            bad++;
            $display("FAIL b2b_period n=%0d: got %0d, want 9", n, cyc - last);
          end
        end
        last = cyc;
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stop: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
